ft601q_tx_packer: RTL and testbench

- Upstream feeder for ft601q_master_tx; drives its wr_en/wr_data FIFO-write interface.
- Accepts a framed stream of 16-bit samples (valid/ready, sof/eof markers) in the ft_clk domain.
- Packs two samples per 32-bit word, wraps each frame in a header word and a trailer word, and throttles on wr_full/ft_rdy.

---
 rtl/ft601q_tx_packer.sv | 199 +++++++++++++++++++
 tb/tb_ft601q_tx_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft601q_tx_packer.sv
// Packs a framed 16-bit sample stream into header/data/trailer 32-bit words for ft601q_master_tx.
// Define FT_TX_CHECKSUM_EN to append a 32-bit sum of the frame's data words after the trailer.
module ft601q_tx_packer #(
    parameter logic [15:0] SYNC_HDR  = 16'hA55A,
    parameter logic [15:0] SYNC_TRL  = 16'h5AA5,
    parameter logic [15:0] PAD_VALUE = 16'h0000
) (
    input  logic        ft_clk,
    input  logic        ft_rst,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    input  logic        s_sof,
    input  logic        s_eof,
    output logic        s_ready,
    input  logic        ft_rdy,
    input  logic        wr_full,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic        busy
);

`ifdef FT_TX_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHdr, StPack, StTrl, StCsum} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHdr, StPack, StTrl} state_e;
`endif

    state_e      state_q, state_d;
    logic        half_q, half_d;
    logic        pad_q, pad_d;
    logic [15:0] low_q, low_d;
    logic [31:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
`ifdef FT_TX_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic        fire;
    logic        slot_free;
    logic        load;
    logic        data_load;
    logic [31:0] load_word;

    always_comb begin
        // Writes are suppressed while reset is held so a stale word never escapes.
        fire        = out_valid_q & ~wr_full & ft_rdy & ~ft_rst;
        slot_free   = ~out_valid_q | fire;
        state_d     = state_q;
        half_d      = half_q;
        pad_d       = pad_q;
        low_d       = low_q;
        out_d       = out_q;
        out_valid_d = out_valid_q & ~fire;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
`ifdef FT_TX_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        s_ready     = 1'b0;
        load        = 1'b0;
        data_load   = 1'b0;
        load_word   = '0;

        unique case (state_q)
            StIdle: begin
                s_ready = ~s_sof;
                if (s_valid && !s_sof) begin
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                end else if (s_valid && s_sof) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_word  = {SYNC_HDR, frame_cnt_q};
                    word_cnt_d = '0;
`ifdef FT_TX_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = StPack;
                end
            end
            StPack: begin
                if (pad_q) begin
                    // Odd-length frame whose last sample arrived while the slot was busy.
                    if (slot_free) begin
                        load      = 1'b1;
                        data_load = 1'b1;
                        load_word = {PAD_VALUE, low_q};
                        half_d    = 1'b0;
                        pad_d     = 1'b0;
                        state_d   = StTrl;
                    end
                end else if (!half_q) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        low_d = s_data;
                        if (s_eof && slot_free) begin
                            load      = 1'b1;
                            data_load = 1'b1;
                            load_word = {PAD_VALUE, s_data};
                            state_d   = StTrl;
                        end else begin
                            half_d = 1'b1;
                            pad_d  = s_eof;
                        end
                    end
                end else begin
                    s_ready = slot_free;
                    if (s_valid && slot_free) begin
                        load      = 1'b1;
                        data_load = 1'b1;
                        load_word = {s_data, low_q};
                        half_d    = 1'b0;
                        if (s_eof) state_d = StTrl;
                    end
                end
            end
            StTrl: begin
                if (slot_free) begin
                    load        = 1'b1;
                    load_word   = {SYNC_TRL, word_cnt_q};
                    frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef FT_TX_CHECKSUM_EN
                    state_d     = StCsum;
`else
                    state_d     = StIdle;
`endif
                end
            end
`ifdef FT_TX_CHECKSUM_EN
            StCsum: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = csum_q;
                    state_d   = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (load) begin
            out_d       = load_word;
            out_valid_d = 1'b1;
        end
        if (data_load) begin
            word_cnt_d = word_cnt_q + 16'd1;
`ifdef FT_TX_CHECKSUM_EN
            csum_d     = csum_q + load_word;
`endif
        end
        if (ft_rst) s_ready = 1'b0;
    end

    always_ff @(posedge ft_clk) begin
        if (ft_rst) begin
            state_q     <= StIdle;
            half_q      <= 1'b0;
            pad_q       <= 1'b0;
            low_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
`ifdef FT_TX_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            pad_q       <= pad_d;
            low_q       <= low_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef FT_TX_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign wr_en     = fire;
    assign wr_data   = out_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ft601q_tx_packer.sv
// Scoreboard bench for ft601q_tx_packer (default build): directed frames, drops, stall and reset.
module tb_ft601q_tx_packer;

    logic        ft_clk = 1'b0;
    logic        ft_rst;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_sof;
    logic        s_eof;
    logic        s_ready;
    logic        ft_rdy;
    logic        wr_full;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [15:0] smp[$];

    always #5 ft_clk = ~ft_clk;

    ft601q_tx_packer dut (
        .ft_clk   (ft_clk),
        .ft_rst   (ft_rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .s_eof    (s_eof),
        .s_ready  (s_ready),
        .ft_rdy   (ft_rdy),
        .wr_full  (wr_full),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .frame_cnt(frame_cnt),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    // Monitor: every FIFO write must match the next expected word.
    always @(negedge ft_clk) begin
        if (wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got=%h", wr_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (wr_data !== e) begin
                    bad++;
                    $display("FAIL write_data got=%h want=%h", wr_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic sof, input logic eof);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eof   = eof;
        forever begin
            @(negedge ft_clk);
            if (s_ready) break;
            n++;
            if (n > 1000) begin
                total++;
                bad++;
                $display("FAIL send_timeout got=stuck want=accept data=%h", d);
                break;
            end
        end
        @(posedge ft_clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eof   = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < smp.size(); i++) send(smp[i], i == 0, i == smp.size() - 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge ft_clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got=%0d_left want=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge ft_clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge ft_clk);
        #1;
        ft_rst = 1'b1;
        repeat (2) @(posedge ft_clk);
        #1;
        ft_rst = 1'b0;
    endtask

    task automatic stall();
        logic [31:0] held;
        repeat (100) @(posedge ft_clk);
        #1;
        wr_full = 1'b1;
        repeat (2) @(posedge ft_clk);
        @(negedge ft_clk);
        chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
        held = wr_data;
        for (int c = 0; c < 18; c++) begin
            @(negedge ft_clk);
            chk("stall_wr_en", {31'd0, wr_en}, 32'd0);
            chk("stall_hold", wr_data, held);
        end
        @(posedge ft_clk);
        #1;
        wr_full = 1'b0;
    endtask

    initial begin
        ft_rst  = 1'b1;
        ft_rdy  = 1'b1;
        wr_full = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        s_eof   = 1'b0;

        // Reset values
        repeat (3) @(posedge ft_clk);
        @(negedge ft_clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge ft_clk);
        #1;
        ft_rst = 1'b0;
        #1;
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, s_ready}, 32'd1);
        s_sof = 1'b1;
        #1;
        chk("idle_sof_ready", {31'd0, s_ready}, 32'd0);
        s_sof = 1'b0;

        // 4-sample frame
        smp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        exp_q = '{32'hA55A0000, 32'h00020001, 32'h00040003, 32'h5AA50002};
        send_frame();
        drain("four");
        chk("four_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("four_busy", {31'd0, busy}, 32'd0);

        // Reset after 5 data words of the second frame (header carries frame_cnt=1)
        exp_q = '{32'hA55A0001, 32'h01010100, 32'h01030102, 32'h01050104,
                  32'h01070106, 32'h01090108};
        for (int i = 0; i < 10; i++) send(16'h0100 + 16'(i), i == 0, 1'b0);
        drain("partial");
        chk("partial_busy", {31'd0, busy}, 32'd1);
        ft_rst = 1'b1;
        @(posedge ft_clk);
        #1;
        ft_rst = 1'b0;
        chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        smp = '{16'h0A0B, 16'h0C0D};
        exp_q = '{32'hA55A0000, 32'h0C0D0A0B, 32'h5AA50001};
        send_frame();
        drain("after_rst");
        chk("after_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // 3-sample frame: pad in high half
        reset_dut();
        smp = '{16'h0011, 16'h0022, 16'h0033};
        exp_q = '{32'hA55A0000, 32'h00220011, 32'h00000033, 32'h5AA50002};
        send_frame();
        drain("three");

        // Samples outside a frame are dropped
        reset_dut();
        send(16'hDEAD, 1'b0, 1'b0);
        send(16'hDEAE, 1'b0, 1'b0);
        send(16'hDEAF, 1'b0, 1'b0);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        smp = '{16'hAAAA, 16'hBBBB};
        exp_q = '{32'hA55A0000, 32'hBBBBAAAA, 32'h5AA50001};
        send_frame();
        drain("drop");
        chk("drop_cnt", {16'd0, drop_cnt}, 32'd3);

        // Single sample frame, sof and eof together
        reset_dut();
        smp = '{16'hBEEF};
        exp_q = '{32'hA55A0000, 32'h0000BEEF, 32'h5AA50001};
        send_frame();
        drain("single");
        chk("single_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // 512-sample frame with a 20-cycle wr_full stall mid-frame
        reset_dut();
        smp.delete();
        exp_q.delete();
        exp_q.push_back(32'hA55A0000);
        for (int i = 0; i < 512; i++) smp.push_back(16'(i + 1));
        for (int k = 0; k < 256; k++) exp_q.push_back({16'(2 * k + 2), 16'(2 * k + 1)});
        exp_q.push_back(32'h5AA50100);
        fork
            send_frame();
            stall();
        join
        drain("long");
        chk("long_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
